// File: rtl/md_unit_if.sv
// Issue/result bundle between the EX stage and the iterative multiply/divide unit.
// The master drives the operation; the slave owns busy/done and the HI/LO pair.
interface md_unit_if #(
  parameter int DATA_W = 32
) ();
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] in_1;
  logic [DATA_W-1:0] in_2;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (output start, op, in_1, in_2, input busy, done, hi, lo);
  modport slave  (input start, op, in_1, in_2, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiply and
// restoring divide, one radix-2 step per cycle, with a final sign-fix cycle.
module md_unit #(
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   md
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e              state_q,    state_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic [DATA_W-1:0]   hi_q,       hi_d;
  logic [DATA_W-1:0]   lo_q,       lo_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic                is_div_q,   is_div_d;
  logic                div0_q,     div0_d;
  logic                quot_neg_q, quot_neg_d;  // also negates the product
  logic                rem_neg_q,  rem_neg_d;
  logic [DATA_W-1:0]   orig_q,     orig_d;
  logic [DATA_W-1:0]   a_q,        a_d;
  logic [DATA_W-1:0]   b_q,        b_d;
  logic [2*DATA_W-1:0] acc_q,      acc_d;
  logic [DATA_W-1:0]   rem_q,      rem_d;

  logic                is_signed;
  logic [DATA_W-1:0]   in1_abs;
  logic [DATA_W-1:0]   in2_abs;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     rem_sh;
  logic                rem_ge;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    div0_d     = div0_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    orig_d     = orig_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    rem_d      = rem_q;

    is_signed = (md.op == OP_MULT) || (md.op == OP_DIV);
    in1_abs   = (is_signed && md.in_1[DATA_W-1]) ? -md.in_1 : md.in_1;
    in2_abs   = (is_signed && md.in_2[DATA_W-1]) ? -md.in_2 : md.in_2;

    // Multiply step: add multiplicand into the upper half, keep the carry on the shift.
    mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, a_q} : '0);

    // Divide step: shift {rem,quot} left and trial-subtract the divisor.
    rem_sh = {rem_q, acc_q[DATA_W-1]};
    rem_ge = rem_sh >= {1'b0, b_q};

    prod_fix = quot_neg_q ? -acc_q : acc_q;
    quot_fix = quot_neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rem_fix  = rem_neg_q  ? -rem_q : rem_q;

    case (state_q)
      IDLE: begin
        if (md.start) begin
          case (md.op)
            OP_MTHI: hi_d = md.in_1;
            OP_MTLO: lo_d = md.in_1;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d   = md.op[1];
              div0_d     = (md.in_2 == '0);
              quot_neg_d = is_signed && (md.in_1[DATA_W-1] ^ md.in_2[DATA_W-1]);
              rem_neg_d  = is_signed && md.in_1[DATA_W-1];
              orig_d     = md.in_1;
              a_d        = in1_abs;
              b_d        = in2_abs;
              // Low half seeds the multiplier (mult) or the dividend/quotient (div).
              acc_d      = {{DATA_W{1'b0}}, md.op[1] ? in1_abs : in2_abs};
              rem_d      = '0;
              cnt_d      = '0;
              busy_d     = 1'b1;
              state_d    = CALC;
            end
            default: ;
          endcase
        end
      end

      CALC: begin
        if (is_div_q) begin
          rem_d = rem_ge ? DATA_W'(rem_sh - {1'b0, b_q}) : rem_sh[DATA_W-1:0];
          acc_d = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-2:0], rem_ge};
        end else begin
          acc_d = {mul_sum, acc_q[DATA_W-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FIX;
      end

      FIX: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (div0_q) begin
          hi_d = orig_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      div0_q     <= 1'b0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      orig_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      div0_q     <= div0_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      orig_q     <= orig_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
